// File: rtl/mux_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mux_regfile_pkg
// Shared definitions for the pin-multiplexed register file and the chip top.
// These are the default geometry values, the sequencer phase type, and helpers
// that derive the beat count and the beat-index width from XLEN and BUS_W.
// -----------------------------------------------------------------------------
package mux_regfile_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int BUS_W_DEFAULT    = 8;
    localparam int NREGS_DEFAULT    = 16;
    localparam int ZERO_REG_DEFAULT = 1;

    // The sequencer is either idle or running beats of a transaction.
    typedef enum logic {
        PH_IDLE   = 1'b0,
        PH_ACTIVE = 1'b1
    } phase_e;

    // Number of bus beats needed to move one register word.
    function automatic int beatsCount(input int xlen, input int busW);
        return xlen / busW;
    endfunction

    // Width of the beat index. It never drops below one bit, so the
    // single-beat case still has a legal vector.
    function automatic int beatsWidth(input int xlen, input int busW);
        int beats;
        beats = xlen / busW;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mux_phase_ctr.sv
// -----------------------------------------------------------------------------
// mux_phase_ctr
// Beat sequencer for the multiplexed register file. It accepts a transaction
// request, steps the beat index LSB-first, and holds that index while stall is
// high. On the final unstalled beat it pulses done, and it can chain directly
// into a new transaction on that same cycle.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   start      : transaction request
//   stall      : freezes the current beat while high
//   accept     : start is being taken this cycle
//   busy       : a transaction is in its beat phase
//   beat_valid : current cycle is an active beat
//   beat_idx   : index of the current beat (0 when idle)
//   done       : single-cycle pulse on the unstalled last beat
// -----------------------------------------------------------------------------
module mux_phase_ctr
    import mux_regfile_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int BW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic          accept,
    output logic          busy,
    output logic          beat_valid,
    output logic [BW-1:0] beat_idx,
    output logic          done
);

    localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

    phase_e        state_q, state_d;
    logic [BW-1:0] idx_q, idx_d;
    logic          lastBeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The index is forced back to zero whenever the sequencer goes idle.
    // Because of that, beat_idx reads 0 outside a transaction without any
    // extra masking. A start is taken only when idle or on the completing
    // last beat, which is what allows back-to-back transactions with no gap.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy       = (state_q == PH_ACTIVE);
        beat_valid = busy;
        beat_idx   = idx_q;
        lastBeat   = busy && (idx_q == LAST_IDX);
        done       = lastBeat && !stall;
        accept     = start && !rst && (!busy || done);

        case (state_q)
            PH_IDLE: begin
                if (accept) begin
                    state_d = PH_ACTIVE;
                    idx_d   = '0;
                end
            end
            PH_ACTIVE: begin
                if (!stall) begin
                    if (lastBeat) begin
                        idx_d   = '0;
                        state_d = accept ? PH_ACTIVE : PH_IDLE;
                    end else begin
                        idx_d = idx_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = PH_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mux_register_file.sv
// -----------------------------------------------------------------------------
// mux_register_file
// Register file whose read and write data move over narrow pin buses, one
// BUS_W slice per beat and LSB-first. A transaction latches two read
// addresses, a write address and a write flag. It then streams both read
// words out while it assembles the write word from rd_dat. The write commits
// on the last unstalled beat, so reads within the same transaction always
// see the old contents.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   start, we           : transaction request and its write flag
//   stall               : hold the current beat
//   rs1_addr, rs2_addr  : read register indices
//   rd_addr             : write register index
//   rd_dat              : write-data beat
//   rs1_dat, rs2_dat    : read-data beats (0 outside active beats)
//   beat_valid, beat_idx: active-beat flag and index
//   busy, done          : transaction in progress / last-beat pulse
// -----------------------------------------------------------------------------
module mux_register_file
    import mux_regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int BUS_W    = BUS_W_DEFAULT,
    parameter  int NREGS    = NREGS_DEFAULT,
    parameter  int ZERO_REG = ZERO_REG_DEFAULT,
    localparam int BEATS    = beatsCount(XLEN, BUS_W),
    localparam int AW       = $clog2(NREGS),
    localparam int BW       = beatsWidth(XLEN, BUS_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             we,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic [AW-1:0]    rd_addr,
    input  logic [BUS_W-1:0] rd_dat,
    output logic [BUS_W-1:0] rs1_dat,
    output logic [BUS_W-1:0] rs2_dat,
    output logic             beat_valid,
    output logic [BW-1:0]    beat_idx,
    output logic             busy,
    output logic             done
);

    // Reject geometries the slicing logic cannot handle.
    if ((XLEN % BUS_W) != 0) begin : gBadBusWidth
        $error("mux_register_file: XLEN must be a multiple of BUS_W");
    end
    if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : gBadRegCount
        $error("mux_register_file: NREGS must be a power of two (>= 2)");
    end

    logic [XLEN-1:0] regs_q [NREGS];
    logic [AW-1:0]   rs1A_q, rs1A_d;
    logic [AW-1:0]   rs2A_q, rs2A_d;
    logic [AW-1:0]   rdA_q, rdA_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] asm_q, asm_d;
    logic [XLEN-1:0] rs1Word, rs2Word;
    logic            accept;
    logic            commitEn;

    mux_phase_ctr #(
        .BEATS (BEATS),
        .BW    (BW)
    ) uPhaseCtr (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .accept     (accept),
        .busy       (busy),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .done       (done)
    );

    // The transaction fields are captured only when a start is accepted.
    // A start seen while busy on a non-final beat therefore leaves the
    // running transaction untouched.
    always_comb begin
        rs1A_d = rs1A_q;
        rs2A_d = rs2A_q;
        rdA_d  = rdA_q;
        we_d   = we_q;
        if (accept) begin
            rs1A_d = rs1_addr;
            rs2A_d = rs2_addr;
            rdA_d  = rd_addr;
            we_d   = we;
        end
    end

    // The assembly buffer takes one slice per unstalled beat. On the last
    // beat, asm_d already contains the final slice, so the commit writes
    // asm_d directly instead of waiting a cycle for asm_q to catch up.
    // Writes to a hardwired zero register are dropped here.
    always_comb begin
        asm_d = asm_q;
        if (beat_valid && !stall) begin
            asm_d[int'(beat_idx)*BUS_W +: BUS_W] = rd_dat;
        end
        commitEn = done && we_q && !((ZERO_REG != 0) && (rdA_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1A_q <= '0;
            rs2A_q <= '0;
            rdA_q  <= '0;
            we_q   <= 1'b0;
            asm_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            rs1A_q <= rs1A_d;
            rs2A_q <= rs2A_d;
            rdA_q  <= rdA_d;
            we_q   <= we_d;
            asm_q  <= asm_d;
            if (commitEn) begin
                regs_q[rdA_q] <= asm_d;
            end
        end
    end

    // Reads come straight from the array with no bypass from the assembly
    // buffer. Both read buses are zeroed outside active beats.
    always_comb begin
        rs1Word = regs_q[rs1A_q];
        rs2Word = regs_q[rs2A_q];
        if ((ZERO_REG != 0) && (rs1A_q == '0)) rs1Word = '0;
        if ((ZERO_REG != 0) && (rs2A_q == '0)) rs2Word = '0;
        rs1_dat = '0;
        rs2_dat = '0;
        if (beat_valid) begin
            rs1_dat = rs1Word[int'(beat_idx)*BUS_W +: BUS_W];
            rs2_dat = rs2Word[int'(beat_idx)*BUS_W +: BUS_W];
        end
    end

endmodule
